// File: rtl/hack_gate_pkg.sv
// Shared types for the 16-bit gate bench: gate op codes, checker states, default width.
package hack_gate_pkg;

  localparam int unsigned GATE_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_NOT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the elementary gates; NOT ignores in2.
module gate_ref_model
  import hack_gate_pkg::*;
#(
  parameter int unsigned WIDTH = GATE_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result_c
);

  // Select the expected gate output for the latched op
  always_comb begin
    result_c = '0;
    case (op)
      OP_OR:   result_c = in1 | in2;
      OP_AND:  result_c = in1 & in2;
      OP_XOR:  result_c = in1 ^ in2;
      default: result_c = ~in1;
    endcase
  end

endmodule

// File: rtl/gate_result_checker.sv
// Response checker for the 16-bit gate bench: two-stage compare pipeline,
// vector/error counters and first-failure capture.
// Optional build macro GATE_CHECKER_STOP_ON_ERROR_EN ends the run on the first mismatch.
module gate_result_checker
  import hack_gate_pkg::*;
#(
  parameter int unsigned WIDTH = GATE_WIDTH,
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_in1,
  output logic [WIDTH-1:0] first_err_in2,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] first_err_exp
);

`ifdef GATE_CHECKER_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] issued;
  logic             first_seen;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_in1;
  logic [WIDTH-1:0] s1_in2;
  logic [WIDTH-1:0] s1_got;

  logic [WIDTH-1:0] exp_c;
  logic             mismatch_c;
  logic [CNT_W-1:0] vec_next_c;

  gate_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op       (op_q),
    .in1      (s1_in1),
    .in2      (s1_in2),
    .result_c (exp_c)
  );

  assign mismatch_c = s1_valid && (exp_c != s1_got);
  assign vec_next_c = vec_count + CNT_W'(1);

  // Run control, stage-1 capture, stage-2 compare/count and first-error capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      op_q          <= OP_OR;
      target        <= '0;
      issued        <= '0;
      first_seen    <= 1'b0;
      s1_valid      <= 1'b0;
      s1_in1        <= '0;
      s1_in2        <= '0;
      s1_got        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_in1 <= '0;
      first_err_in2 <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q          <= op_e'(op);
            target        <= num_vectors;
            issued        <= '0;
            first_seen    <= 1'b0;
            s1_valid      <= 1'b0;
            vec_count     <= '0;
            err_count     <= '0;
            first_err_in1 <= '0;
            first_err_in2 <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            if (num_vectors == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end

        S_RUN: begin
          // Stage 1: accept strobes only until the target count has been issued
          s1_valid <= 1'b0;
          if (vec_valid && (issued != target)) begin
            s1_valid <= 1'b1;
            s1_in1   <= in1;
            s1_in2   <= in2;
            s1_got   <= dut_out;
            issued   <= issued + CNT_W'(1);
          end
          // Stage 2: count, compare and record the first failure
          if (s1_valid) begin
            vec_count <= vec_next_c;
            if (mismatch_c) begin
              if (err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
              end
              if (!first_seen) begin
                first_seen    <= 1'b1;
                first_err_in1 <= s1_in1;
                first_err_in2 <= s1_in2;
                first_err_got <= s1_got;
                first_err_exp <= exp_c;
              end
            end
            if ((vec_next_c == target) || (STOP_ON_ERR && mismatch_c)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch_c;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_result_checker.sv
// Scoreboard bench for gate_result_checker: expected counter values are queued
// as vectors are driven and popped whenever the checker advances vec_count.
module tb_gate_result_checker;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 17;

`ifdef GATE_CHECKER_STOP_ON_ERROR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, vec_valid;
  logic [1:0]    op;
  logic [CW-1:0] num_vectors;
  logic [W-1:0]  in1, in2, dut_out;
  logic          busy, done, pass;
  logic [CW-1:0] vec_count, err_count;
  logic [W-1:0]  first_err_in1, first_err_in2, first_err_got, first_err_exp;

  gate_result_checker dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .num_vectors   (num_vectors),
    .vec_valid     (vec_valid),
    .in1           (in1),
    .in2           (in2),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .vec_count     (vec_count),
    .err_count     (err_count),
    .first_err_in1 (first_err_in1),
    .first_err_in2 (first_err_in2),
    .first_err_got (first_err_got),
    .first_err_exp (first_err_exp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] vc;
    logic [CW-1:0] ec;
  } sb_t;

  sb_t           sb_q[$];
  sb_t           sb_e;
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] prev_vc = '0;

  // reference model state
  logic [1:0] m_op;
  int         m_target, m_issued, m_vc, m_ec;
  bit         m_stopped, m_first;
  logic [W-1:0] m_f1, m_f2, m_fg, m_fe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gold(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (o)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic model_clear();
    m_issued = 0; m_vc = 0; m_ec = 0; m_stopped = 0; m_first = 0;
    m_f1 = '0; m_f2 = '0; m_fg = '0; m_fe = '0;
  endtask

  // reset asserted together with start and a strobe: reset must win
  task automatic do_reset();
    reset = 1'b1; start = 1'b1; vec_valid = 1'b1; num_vectors = CW'(5);
    @(posedge clk); #1;
    start = 1'b0; vec_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    m_target = 0;
    sb_q.delete();
  endtask

  task automatic start_run(input logic [1:0] o, input int n);
    op = o; num_vectors = CW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_op = o; m_target = n;
    model_clear();
  endtask

  task automatic drive_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] flip);
    logic [W-1:0] e;
    e = gold(m_op, a, b);
    in1 = a; in2 = b; dut_out = e ^ flip; vec_valid = 1'b1;
    if (m_issued < m_target && !m_stopped) begin
      m_issued++;
      m_vc++;
      if (flip != '0) begin
        m_ec++;
        if (!m_first) begin
          m_first = 1; m_f1 = a; m_f2 = b; m_fg = e ^ flip; m_fe = e;
        end
        if (STOP) m_stopped = 1;
      end
      sb_q.push_back('{vc: CW'(m_vc), ec: CW'(m_ec)});
    end
    @(posedge clk); #1;
    vec_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    @(negedge clk);
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(done), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic end_checks(input string t);
    check({t, ".busy"}, 32'(busy), 32'(0));
    check({t, ".done"}, 32'(done), 32'(1));
    check({t, ".pass"}, 32'(pass), 32'(m_ec == 0));
    check({t, ".vc"},   32'(vec_count), 32'(m_vc));
    check({t, ".ec"},   32'(err_count), 32'(m_ec));
    check({t, ".f1"},   32'(first_err_in1), 32'(m_f1));
    check({t, ".f2"},   32'(first_err_in2), 32'(m_f2));
    check({t, ".fg"},   32'(first_err_got), 32'(m_fg));
    check({t, ".fe"},   32'(first_err_exp), 32'(m_fe));
    check({t, ".sb_left"}, 32'(sb_q.size()), 32'(0));
  endtask

  // scoreboard monitor: every advance of vec_count must match the next queued entry
  always @(negedge clk) begin
    if (!reset && vec_count != prev_vc && vec_count != '0) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", 32'(vec_count), 32'(prev_vc));
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_vc", 32'(vec_count), 32'(sb_e.vc));
        check("sb_ec", 32'(err_count), 32'(sb_e.ec));
      end
    end
    prev_vc = vec_count;
  end

  initial begin
    reset = 1'b0; start = 1'b0; vec_valid = 1'b0; op = 2'd0; num_vectors = '0;
    in1 = '0; in2 = '0; dut_out = '0;
    m_op = 2'd0; m_target = 0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    check("rst.busy", 32'(busy), 32'(0));
    check("rst.done", 32'(done), 32'(0));
    check("rst.pass", 32'(pass), 32'(0));
    check("rst.vc",   32'(vec_count), 32'(0));
    check("rst.ec",   32'(err_count), 32'(0));
    check("rst.f1",   32'(first_err_in1), 32'(0));

    // strobes in IDLE are ignored
    drive_vec(16'h1234, 16'h4321, 16'hFFFF);
    drive_vec(16'h0001, 16'h0002, 16'h0000);
    @(posedge clk); #1;
    check("idle.vc", 32'(vec_count), 32'(0));
    check("idle.ec", 32'(err_count), 32'(0));

    // OR, 4 correct vectors, then late strobes that must be dropped
    start_run(2'd0, 4);
    for (int i = 0; i < 4; i++) drive_vec(W'(i), W'(i), 16'h0000);
    @(negedge clk);
    check("t1.lat1_done", 32'(done), 32'(0));
    drive_vec(16'h00AA, 16'h0055, 16'h0001);
    check("t1.lat2_done", 32'(done), 32'(1));
    drive_vec(16'h00AA, 16'h0055, 16'h0001);
    wait_done(10);
    end_checks("t1");
    check("t1.vc_abs", 32'(vec_count), 32'(4));

    // OR single forced mismatch
    start_run(2'd0, 1);
    drive_vec(16'h00F0, 16'h0F00, 16'h0001);
    wait_done(10);
    end_checks("t2");
    check("t2.f_got_abs", 32'(first_err_got), 32'h0FF1);
    check("t2.f_exp_abs", 32'(first_err_exp), 32'h0FF0);

    // NOT full sweep, extra strobe at the 0xFFFF->0x0000 wrap is dropped
    start_run(2'd3, 65536);
    for (int i = 0; i <= 65536; i++) drive_vec(W'(i), 16'hFFFF, 16'h0000);
    wait_done(10);
    end_checks("t3");
    check("t3.vc_abs", 32'(vec_count), 32'h10000);

    // XOR, mismatches at vectors 2 and 5; a start mid-run is ignored
    start_run(2'd2, 8);
    op = 2'd0; num_vectors = CW'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 8; i++)
      drive_vec(W'(i * 16'h0123), 16'h5A5A ^ W'(i),
                (i == 2) ? 16'h0100 : ((i == 5) ? 16'h8000 : 16'h0000));
    wait_done(10);
    end_checks("t4");
    check("t4.f1_abs", 32'(first_err_in1), 32'h0246);

    // reset mid-run after 3 vectors, then a clean restart
    start_run(2'd1, 5);
    for (int i = 1; i <= 3; i++)
      drive_vec(16'hF0F0 + W'(i), 16'h3C3C, (i == 2) ? 16'h0004 : 16'h0000);
    @(posedge clk); #1;
    check("t5.pre_vc", 32'(vec_count), 32'(3));
    do_reset();
    check("t5.rst_vc", 32'(vec_count), 32'(0));
    check("t5.rst_ec", 32'(err_count), 32'(0));
    check("t5.rst_f1", 32'(first_err_in1), 32'(0));
    start_run(2'd1, 2);
    drive_vec(16'hAAAA, 16'h0FF0, 16'h0000);
    drive_vec(16'h5555, 16'hFFFF, 16'h0000);
    wait_done(10);
    end_checks("t5");

    // mismatch at vector 3 of 10: stops early only with the stop-on-error build
    start_run(2'd0, 10);
    for (int i = 1; i <= 10; i++)
      drive_vec(W'(i << 4), W'(i), (i == 3) ? 16'h0010 : 16'h0000);
    wait_done(10);
    end_checks("t6");
    check("t6.vc_abs", 32'(vec_count), STOP ? 32'(3) : 32'(10));

    // zero-length run finishes immediately with pass
    start_run(2'd2, 0);
    end_checks("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gate_result_checker.md
Name: gate_result_checker

Overview:
- Synthesizable response checker for the elementary 16-bit logic gates (Or16, And16, Xor16, Not16).
- Sits on the DUT output side of a gate bench: samples operand and result vectors on each strobe, recomputes the expected result, and counts mismatches.
- Reports pass/fail once a programmed number of vectors has been checked.
- Captures the first failing vector for waveform and debug readout.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CNT_W, 17, width of the vector and error counters; must hold 2^WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; arms the checker from IDLE or DONE.
- op  input  2  gate under test: 0=OR, 1=AND, 2=XOR, 3=NOT (NOT uses in1 only).
- num_vectors  input  CNT_W  vectors to check; latched on start.
- vec_valid  input  1  strobe: in1/in2/dut_out hold a vector to check this cycle.
- in1  input  WIDTH  operand A as applied to the DUT.
- in2  input  WIDTH  operand B as applied to the DUT.
- dut_out  input  WIDTH  DUT result for in1/in2.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  done and err_count==0.
- vec_count  output  CNT_W  vectors checked since start.
- err_count  output  CNT_W  mismatches since start; saturates at all-ones.
- first_err_in1  output  WIDTH  in1 of first mismatch.
- first_err_in2  output  WIDTH  in2 of first mismatch.
- first_err_got  output  WIDTH  dut_out of first mismatch.
- first_err_exp  output  WIDTH  expected value of first mismatch.

Behaviour:
- Reset, synchronous active-high: state=IDLE; busy, done, pass=0; vec_count, err_count=0; all first_err_* =0. Reset dominates start and vec_valid in the same cycle. Reset mid-RUN aborts with no partial result retained.
- States:
  - IDLE: start -> RUN.
  - RUN: the cycle in which vec_count reaches the latched target -> DONE.
  - DONE: holds results; start -> RUN.
  - start while in RUN is ignored.
- On start: latch op and num_vectors; clear both counters, first_err_* and the internal first-error flag.
- start with num_vectors==0 goes directly to DONE next cycle with pass=1.
- Pipeline stage 1: when vec_valid is high in RUN, register in1, in2, dut_out and valid into stage 1.
- Pipeline stage 2: the next cycle, compare against the expected value, increment vec_count, and increment err_count on mismatch.
  - Total latency from strobe to counter update is 2 cycles.
  - Back-to-back strobes on every cycle are supported.
- Expected value: in1|in2, in1&in2, in1^in2, or ~in1, selected by the latched op. Compare over all WIDTH bits.
- Strobes arriving after the target count is issued are dropped and do not change the counters.
- The vector still in stage 1 when the target is reached completes and is counted.
- vec_valid outside RUN is ignored.
- First mismatch in a run loads first_err_*; later mismatches do not overwrite them.
- err_count saturates at all-ones and never wraps. vec_count cannot exceed the target.
- done, pass, counters and first_err_* are registered outputs, stable from entry to DONE until the next start or reset.

Optional Feature:
- Macro: GATE_CHECKER_STOP_ON_ERROR_EN.
- Defined: the first mismatch moves RUN -> DONE in the same cycle err_count becomes 1. pass=0, vec_count includes the failing vector, and later strobes are ignored.
- Undefined: the run always continues to num_vectors regardless of mismatches.

Decomposition:
- Shared package hack_gate_pkg:
  - op encodings OP_OR, OP_AND, OP_XOR, OP_NOT.
  - state encodings S_IDLE, S_RUN, S_DONE.
  - default WIDTH.
- Sub-module gate_ref_model: purely combinational expected-result function of op, in1, in2. The bench may reuse it.

Test Plan:
- Reset, then start op=OR, num_vectors=4, with in1/in2 from 0x0000 upward and a correct DUT -> done after the last vector +2 cycles; vec_count=4, err_count=0, pass=1.
- op=OR, vector in1=0x00F0, in2=0x0F00, dut_out forced 0x0FF1 -> err_count=1, pass=0; first_err_* = 0x00F0/0x0F00/0x0FF1/0x0FF0.
- op=NOT, num_vectors=65536, in1 sweeping 0x0000..0xFFFF, in2=0xFFFF, correct DUT -> vec_count=0x10000, pass=1. The 0xFFFF->0x0000 wrap of in1 causes no false errors.
- Two mismatches, at vector 2 then vector 5 -> first_err_* reflect vector 2 only; err_count=2.
- Assert reset mid-RUN after 3 vectors, then restart with num_vectors=2 -> counters restart from 0; done after 2 vectors; no stale first_err_*.
- With GATE_CHECKER_STOP_ON_ERROR_EN, num_vectors=10, mismatch at vector 3 -> done with vec_count=3, err_count=1; strobes 4..10 ignored.
